// File: rtl/clause_db_scanner.sv
// Clause-DB scanner: reads one variable's clause-occupancy row and streams the
// indices of its set bits, lowest first. Optional SCAN_CNT_EN adds occ_cnt.
module clause_db_scanner #(
  parameter int CLAUSE_NUM = 7,
  parameter int CLAUSE_LOG = 3,
  parameter int VAR_NUM    = 7,
  parameter int VAR_LOG    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [VAR_LOG-1:0]    req_var,
  output logic                  db_en,
  output logic                  db_write,
  output logic [VAR_LOG-1:0]    db_addr,
  input  logic [CLAUSE_NUM-1:0] db_rdata,
  output logic                  cl_valid,
  input  logic                  cl_ready,
  output logic [CLAUSE_LOG-1:0] cl_idx,
  output logic                  cl_last,
  output logic                  done,
  output logic                  empty
`ifdef SCAN_CNT_EN
  ,
  output logic [CLAUSE_LOG:0]   occ_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_SCAN = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  localparam logic [VAR_LOG:0] LP_VAR_NUM = (VAR_LOG+1)'(VAR_NUM);

  state_t                r_state;
  logic [CLAUSE_NUM-1:0] r_mask;
  logic [VAR_LOG-1:0]    r_var;
  logic                  r_oob;
  logic                  w_oob;
  logic [CLAUSE_NUM-1:0] w_cap;
  logic [CLAUSE_NUM-1:0] w_next;

  function automatic logic [CLAUSE_LOG-1:0] f_lowest(input logic [CLAUSE_NUM-1:0] m);
    f_lowest = '0;
    for (int i = CLAUSE_NUM-1; i >= 0; i--)
      if (m[i]) f_lowest = i[CLAUSE_LOG-1:0];
  endfunction

  function automatic logic f_one_hot(input logic [CLAUSE_NUM-1:0] m);
    f_one_hot = (m != '0) && ((m & (m - 1'b1)) == '0);
  endfunction

  assign w_oob    = ({1'b0, req_var} >= LP_VAR_NUM);
  // Rows that do not exist are never read; they scan as an empty mask.
  assign w_cap    = r_oob ? '0 : db_rdata;
  assign w_next   = r_mask & (r_mask - 1'b1);
  assign db_write = 1'b0;
  assign db_addr  = r_var;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mask    <= '0;
      r_var     <= '0;
      r_oob     <= 1'b0;
      req_ready <= 1'b1;
      db_en     <= 1'b0;
      cl_valid  <= 1'b0;
      cl_idx    <= '0;
      cl_last   <= 1'b0;
      done      <= 1'b0;
      empty     <= 1'b0;
    end else if (flush) begin
      r_state   <= S_IDLE;
      r_mask    <= '0;
      req_ready <= 1'b1;
      db_en     <= 1'b0;
      cl_valid  <= 1'b0;
      cl_last   <= 1'b0;
      done      <= 1'b0;
      empty     <= 1'b0;
    end else begin
      done  <= 1'b0;
      empty <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_var     <= req_var;
            r_oob     <= w_oob;
            req_ready <= 1'b0;
            db_en     <= !w_oob;
            r_state   <= w_oob ? S_CAP : S_RD;
          end
        end
        S_RD: begin
          db_en   <= 1'b0;
          r_state <= S_CAP;
        end
        S_CAP: begin
          r_mask <= w_cap;
          if (w_cap != '0) begin
            cl_valid <= 1'b1;
            cl_idx   <= f_lowest(w_cap);
            cl_last  <= f_one_hot(w_cap);
            r_state  <= S_SCAN;
          end else begin
            done    <= 1'b1;
            empty   <= 1'b1;
            r_state <= S_FIN;
          end
        end
        S_SCAN: begin
          if (cl_valid && cl_ready) begin
            r_mask <= w_next;
            if (cl_last) begin
              cl_valid <= 1'b0;
              cl_last  <= 1'b0;
              done     <= 1'b1;
              r_state  <= S_FIN;
            end else begin
              cl_idx  <= f_lowest(w_next);
              cl_last <= f_one_hot(w_next);
            end
          end
        end
        S_FIN: begin
          req_ready <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SCAN_CNT_EN
  function automatic logic [CLAUSE_LOG:0] f_popcnt(input logic [CLAUSE_NUM-1:0] m);
    f_popcnt = '0;
    for (int i = 0; i < CLAUSE_NUM; i++)
      f_popcnt = f_popcnt + (CLAUSE_LOG+1)'(m[i]);
  endfunction

  // Count is taken from the same mask the scan starts from and held until reloaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      occ_cnt <= '0;
    else if (!flush && r_state == S_CAP)
      occ_cnt <= f_popcnt(w_cap);
  end
`endif

endmodule
